// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard controller.
// Detects load-use hazards and control-flow instructions (JAL, JALR, B-type)
// and holds the pipeline for a configurable number of bubble cycles.
// Every output is registered. stall_total_o counts stall cycles and saturates.
module hazard_ctrl #(
    parameter int JAL_BUBBLES   = 1,
    parameter int BR_BUBBLES    = 2,
    parameter int JALR_BUBBLES  = 2,
    parameter int LU_BUBBLES    = 1,
    parameter int CNT_W         = 4,
    parameter int EARLY_RELEASE = 0
) (
    input  logic              clk_cpu,
    input  logic              rst_n_i,
    input  logic [31:0]       inst_i,
    input  logic              inst_valid_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              br_resolve_i,
    input  logic              br_taken_i,
    output logic              have_inst_o,
    output logic              pipline_stop,
    output logic [1:0]        stall_cause_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [15:0]       stall_total_o
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CTRL_STALL = 2'd1;
    localparam logic [1:0] LU_STALL   = 2'd2;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_CTRL = 2'd1;
    localparam logic [1:0] CAUSE_LU   = 2'd2;

    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    localparam logic [CNT_W-1:0] JAL_N  = CNT_W'(JAL_BUBBLES);
    localparam logic [CNT_W-1:0] BR_N   = CNT_W'(BR_BUBBLES);
    localparam logic [CNT_W-1:0] JALR_N = CNT_W'(JALR_BUBBLES);
    localparam logic [CNT_W-1:0] LU_N   = CNT_W'(LU_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Decode fields
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_jal;
    logic       is_jalr;
    logic       is_br;
    logic       rs1_used;
    logic       rs2_used;
    logic       lu_hazard;
    logic [CNT_W-1:0] ctrl_n;

    // Immediate/funct/rd bits are irrelevant to hazard detection
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_i[31:25], inst_i[14:7]};

    assign opcode = inst_i[6:0];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];

    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_br   = (opcode == OP_B);

    // Only U-type and JAL lack an rs1; only R/S/B read rs2
    assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jal);
    assign rs2_used = (opcode == OP_R) || (opcode == OP_S) || is_br;

    // x0 is never a real dependency, so a load to x0 cannot cause a hazard
    assign lu_hazard = inst_valid_i && ex_is_load_i && (ex_rd_i != 5'd0) &&
                       ((rs1_used && (rs1 == ex_rd_i)) ||
                        (rs2_used && (rs2 == ex_rd_i)));

    // Bubble count for the control instruction in decode (0 = not control or no stall)
    always_comb begin
        ctrl_n = '0;
        if (is_jal) begin
            ctrl_n = JAL_N;
        end else if (is_br) begin
            ctrl_n = BR_N;
        end else if (is_jalr) begin
            ctrl_n = JALR_N;
        end
    end

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cause_reg, cause_next;
    logic             br_flag_reg, br_flag_next;
    logic             stop_reg, stop_next;
    logic             have_reg, have_next;
    logic [15:0]      total_reg, total_next;

    // Next-state: triggers only from IDLE; stall states count down and ignore decode
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cause_next   = cause_reg;
        br_flag_next = br_flag_reg;
        case (state_reg)
            IDLE: begin
                cnt_next   = '0;
                cause_next = CAUSE_NONE;
                if (lu_hazard && (LU_BUBBLES > 0)) begin
                    state_next   = LU_STALL;
                    cnt_next     = LU_N;
                    cause_next   = CAUSE_LU;
                    br_flag_next = 1'b0;
                end else if (inst_valid_i && (ctrl_n != '0)) begin
                    state_next   = CTRL_STALL;
                    cnt_next     = ctrl_n;
                    cause_next   = CAUSE_CTRL;
                    br_flag_next = is_br;
                end
            end
            CTRL_STALL: begin
                // A resolved not-taken branch needs no further flush bubbles
                if (((EARLY_RELEASE != 0) && br_flag_reg && br_resolve_i && !br_taken_i) ||
                    (cnt_reg == CNT_ONE)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    cause_next = CAUSE_NONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            LU_STALL: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    cause_next = CAUSE_NONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                cause_next = CAUSE_NONE;
            end
        endcase

        stop_next = (state_next != IDLE);
        have_next = !stop_next;

        // Count cycles in which the stall output is currently asserted, no wrap
        total_next = total_reg;
        if (stop_reg && (total_reg != 16'hFFFF)) begin
            total_next = total_reg + 16'd1;
        end
    end

    // State and output registers; reset clears everything including fetch enable
    always_ff @(posedge clk_cpu or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cause_reg   <= CAUSE_NONE;
            br_flag_reg <= 1'b0;
            stop_reg    <= 1'b0;
            have_reg    <= 1'b0;
            total_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cause_reg   <= cause_next;
            br_flag_reg <= br_flag_next;
            stop_reg    <= stop_next;
            have_reg    <= have_next;
            total_reg   <= total_next;
        end
    end

    assign have_inst_o   = have_reg;
    assign pipline_stop  = stop_reg;
    assign stall_cause_o = cause_reg;
    assign stall_cnt_o   = cnt_reg;
    assign stall_total_o = total_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Stimulus pushes the expected post-edge output snapshot into a queue;
// a monitor pops and compares one entry per clock edge.
module tb_hazard_ctrl;

    logic clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // Default-parameter instance
    logic        d_rst_n, d_valid, d_load, d_res, d_tak;
    logic [31:0] d_inst;
    logic [4:0]  d_rd;
    logic        d_have, d_stop;
    logic [1:0]  d_cause;
    logic [3:0]  d_cnt;
    logic [15:0] d_total;

    // Early-release instance, BR=3, JAL=0
    logic        e_rst_n, e_valid, e_load, e_res, e_tak;
    logic [31:0] e_inst;
    logic [4:0]  e_rd;
    logic        e_have, e_stop;
    logic [1:0]  e_cause;
    logic [3:0]  e_cnt;
    logic [15:0] e_total;

    // Saturation instance, long branch stalls
    logic        s_rst_n, s_valid, s_load, s_res, s_tak;
    logic [31:0] s_inst;
    logic [4:0]  s_rd;
    logic        s_have, s_stop;
    logic [1:0]  s_cause;
    logic [7:0]  s_cnt;
    logic [15:0] s_total;

    hazard_ctrl u_def (
        .clk_cpu(clk_cpu), .rst_n_i(d_rst_n), .inst_i(d_inst), .inst_valid_i(d_valid),
        .ex_is_load_i(d_load), .ex_rd_i(d_rd), .br_resolve_i(d_res), .br_taken_i(d_tak),
        .have_inst_o(d_have), .pipline_stop(d_stop), .stall_cause_o(d_cause),
        .stall_cnt_o(d_cnt), .stall_total_o(d_total)
    );

    hazard_ctrl #(.JAL_BUBBLES(0), .BR_BUBBLES(3), .EARLY_RELEASE(1)) u_er (
        .clk_cpu(clk_cpu), .rst_n_i(e_rst_n), .inst_i(e_inst), .inst_valid_i(e_valid),
        .ex_is_load_i(e_load), .ex_rd_i(e_rd), .br_resolve_i(e_res), .br_taken_i(e_tak),
        .have_inst_o(e_have), .pipline_stop(e_stop), .stall_cause_o(e_cause),
        .stall_cnt_o(e_cnt), .stall_total_o(e_total)
    );

    hazard_ctrl #(.BR_BUBBLES(255), .CNT_W(8)) u_sat (
        .clk_cpu(clk_cpu), .rst_n_i(s_rst_n), .inst_i(s_inst), .inst_valid_i(s_valid),
        .ex_is_load_i(s_load), .ex_rd_i(s_rd), .br_resolve_i(s_res), .br_taken_i(s_tak),
        .have_inst_o(s_have), .pipline_stop(s_stop), .stall_cause_o(s_cause),
        .stall_cnt_o(s_cnt), .stall_total_o(s_total)
    );

    localparam logic [31:0] I_BEQ0  = 32'h0000_0063; // beq x0,x0
    localparam logic [31:0] I_ADD   = 32'h0002_80B3; // add x1,x5,x0
    localparam logic [31:0] I_LUI   = 32'h0002_82B7; // lui x5 with rs1 field = 5
    localparam logic [31:0] I_SW    = 32'h0050_2023; // sw x5,0(x0)
    localparam logic [31:0] I_BEQ5  = 32'h0002_8063; // beq x5,x0
    localparam logic [31:0] I_JALR  = 32'h0000_0067;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;

    typedef struct packed {
        int          cyc;
        int          dut;
        logic [27:0] exp; // {have, stop, cause, cnt[7:0], total}
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Push expected outputs after the coming edge, then advance to the next negedge
    task automatic step(input string nm, input int dut, input logic h, input logic s,
                        input logic [1:0] c, input logic [7:0] n, input logic [15:0] t);
        exp_t e;
        e.cyc = cyc + 1;
        e.dut = dut;
        e.exp = {h, s, c, n, t};
        q.push_back(e);
        qn.push_back(nm);
        @(negedge clk_cpu);
    endtask

    // Monitor: after each edge, compare every entry scheduled for this cycle
    initial begin
        exp_t        e;
        string       nm;
        logic [27:0] act;
        forever begin
            @(posedge clk_cpu);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                nm = qn.pop_front();
                if (e.cyc < cyc) begin
                    chk({"stale_", nm}, e.cyc, cyc);
                end else begin
                    if (e.dut == 0)
                        act = {d_have, d_stop, d_cause, 4'b0, d_cnt, d_total};
                    else
                        act = {e_have, e_stop, e_cause, 4'b0, e_cnt, e_total};
                    chk(nm, {4'b0, act}, {4'b0, e.exp});
                end
            end
        end
    end

    task automatic def_er_seq();
        // Asynchronous reset state
        #3;
        chk("reset_state", {d_have, d_stop, d_cause, d_cnt, d_total}, 24'h0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        d_rst_n = 1'b1;
        e_rst_n = 1'b1;
        step("rst_release", 0, 1, 0, 0, 0, 0);

        // B-type default: 2 stall cycles
        d_inst = I_BEQ0; d_valid = 1;
        step("br_stall1", 0, 0, 1, 1, 2, 0);
        d_valid = 0;
        step("br_stall2", 0, 0, 1, 1, 1, 1);
        step("br_exit", 0, 1, 0, 0, 0, 2);
        step("br_idle", 0, 1, 0, 0, 0, 2);

        // Load-use via rs1
        d_inst = I_ADD; d_valid = 1; d_load = 1; d_rd = 5;
        step("lu_add", 0, 0, 1, 2, 1, 2);
        d_valid = 0; d_load = 0;
        step("lu_add_exit", 0, 1, 0, 0, 0, 3);
        // ex_rd = x0 never hazards even though rs2 field = 0
        d_valid = 1; d_load = 1; d_rd = 0;
        step("lu_rd0", 0, 1, 0, 0, 0, 3);
        // LUI does not read rs1
        d_inst = I_LUI; d_rd = 5;
        step("lu_lui", 0, 1, 0, 0, 0, 3);
        // Store reads rs2
        d_inst = I_SW;
        step("lu_sw", 0, 0, 1, 2, 1, 3);
        d_valid = 0; d_load = 0;
        step("lu_sw_exit", 0, 1, 0, 0, 0, 4);

        // Load-use wins over branch, branch re-evaluated afterwards
        d_inst = I_BEQ5; d_valid = 1; d_load = 1; d_rd = 5;
        step("prio_lu", 0, 0, 1, 2, 1, 4);
        d_load = 0;
        step("prio_exit", 0, 1, 0, 0, 0, 5);
        step("prio_ctrl1", 0, 0, 1, 1, 2, 5);
        d_valid = 0;
        step("prio_ctrl2", 0, 0, 1, 1, 1, 6);
        step("prio_done", 0, 1, 0, 0, 0, 7);

        // JALR: 2 cycles
        d_inst = I_JALR; d_valid = 1;
        step("jalr1", 0, 0, 1, 1, 2, 7);
        d_valid = 0;
        step("jalr2", 0, 0, 1, 1, 1, 8);
        step("jalr_exit", 0, 1, 0, 0, 0, 9);

        // JAL held valid: no retrigger on the exit edge
        d_inst = I_JAL; d_valid = 1;
        step("jal1", 0, 0, 1, 1, 1, 9);
        step("jal_exit", 0, 1, 0, 0, 0, 10);
        step("jal_again", 0, 0, 1, 1, 1, 10);
        d_valid = 0;
        step("jal_again_exit", 0, 1, 0, 0, 0, 11);

        // Early release disabled: not-taken resolution is ignored
        d_inst = I_BEQ0; d_valid = 1;
        step("noer1", 0, 0, 1, 1, 2, 11);
        d_valid = 0; d_res = 1; d_tak = 0;
        step("noer2", 0, 0, 1, 1, 1, 12);
        d_res = 0;
        step("noer_exit", 0, 1, 0, 0, 0, 13);

        // Reset mid-stall clears outputs without a clock edge
        d_valid = 1;
        step("rst_mid_stall", 0, 0, 1, 1, 2, 13);
        d_valid = 0;
        #2 d_rst_n = 1'b0;
        #1;
        chk("async_rst", {d_have, d_stop, d_cause, d_cnt, d_total}, 24'h0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        d_rst_n = 1'b1;
        step("rst_release2", 0, 1, 0, 0, 0, 0);

        // Early-release instance
        e_inst = I_JAL; e_valid = 1;
        step("er_jal0", 1, 1, 0, 0, 0, 0);
        e_inst = I_BEQ0;
        step("er_br1", 1, 0, 1, 1, 3, 0);
        e_valid = 0; e_res = 1; e_tak = 0;
        step("er_release", 1, 1, 0, 0, 0, 1);
        e_res = 0; e_valid = 1;
        step("er_brt1", 1, 0, 1, 1, 3, 1);
        e_valid = 0; e_res = 1; e_tak = 1;
        step("er_brt2", 1, 0, 1, 1, 2, 2);
        e_res = 0;
        step("er_brt3", 1, 0, 1, 1, 1, 3);
        step("er_brt_exit", 1, 1, 0, 0, 0, 4);
        e_inst = I_JALR; e_valid = 1;
        step("er_jalr1", 1, 0, 1, 1, 2, 4);
        e_valid = 0; e_res = 1; e_tak = 0;
        step("er_jalr2", 1, 0, 1, 1, 1, 5);
        e_res = 0;
        step("er_jalr_exit", 1, 1, 0, 0, 0, 6);
    endtask

    // Continuous branches: 255 stall cycles per 256 edges
    task automatic sat_seq();
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        s_rst_n = 1'b1;
        s_inst  = I_BEQ0;
        s_valid = 1'b1;
        repeat (60000) @(negedge clk_cpu);
        chk("sat_not_yet", {31'b0, (s_total > 16'd59000) && (s_total < 16'hFFFF)}, 32'd1);
        repeat (6000) @(negedge clk_cpu);
        chk("sat_hold", {16'b0, s_total}, 32'h0000_FFFF);
        chk("sat_stop", {31'b0, s_stop}, 32'd1);
    endtask

    initial begin
        d_rst_n = 0; d_inst = 0; d_valid = 0; d_load = 0; d_rd = 0; d_res = 0; d_tak = 0;
        e_rst_n = 0; e_inst = 0; e_valid = 0; e_load = 0; e_rd = 0; e_res = 0; e_tak = 0;
        s_rst_n = 0; s_inst = 0; s_valid = 0; s_load = 0; s_rd = 0; s_res = 0; s_tak = 0;
        fork
            def_er_seq();
            sat_seq();
        join
        repeat (3) @(negedge clk_cpu);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
